draw_tetromino: RTL
===================

DRAW_TETROMINO -- requirements
Module: draw_tetromino

Interface
Parameters:
REQ-001 BOARD_X0, 280, left pixel column of board cell column 0.
REQ-002 BOARD_Y0, 60, top pixel row of board cell row 0.
REQ-003 CELL, 24, cell edge in pixels; board is 10 columns x 20 rows.

Ports:
REQ-004 pclk  in  1  pixel clock; one clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 hcount_in, vcount_in  in  11 each  timing counters.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes.
REQ-008 rgb_in  in  12  background pixel.
REQ-009 xpos, ypos  in  12 each  piece origin, in cells, from the piece controller.
REQ-010 block  in  3  shape code 0..6 = I,O,T,S,Z,J,L; 7 = none.
REQ-011 rot  in  3  rotation count; only rot[1:0] used.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  same widths as inputs  delayed stream.

Function
REQ-013 Snapshot: xpos, ypos, block and rot SHALL be captured into shadow registers on the cycle after a vblnk_in 0->1 transition; input changes at other times are ignored until the next such edge.
REQ-014 Latency SHALL be exactly 2 pclk for every output; all timing outputs equal the inputs delayed 2 cycles.
REQ-015 Cell tracking SHALL use counters, not dividers: the column/sub-pixel counter loads 0/0 when hcount_in == BOARD_X0, the sub-pixel counter wraps at CELL-1 and increments the column; rows are handled the same way at vcount_in == BOARD_Y0 on each line start.
REQ-016 Pixels outside 10x20*CELL board area SHALL be treated as non-piece.
REQ-017 Rotation-0 mino offsets (dx,dy): I (0,1)(1,1)(2,1)(3,1); O (1,0)(2,0)(1,1)(2,1); T (1,0)(0,1)(1,1)(2,1); S (1,0)(2,0)(0,1)(1,1); Z (0,0)(1,0)(1,1)(2,1); J (0,0)(0,1)(1,1)(2,1); L (2,0)(0,1)(1,1)(2,1).
REQ-018 Each rotation step SHALL map (dx,dy) -> (3-dy,dx) for I and (2-dy,dx) for T,S,Z,J,L, applied rot[1:0] times; O is never rotated.
REQ-019 Mino cell = (xpos+dx, ypos+dy) in 13-bit arithmetic; a mino with column > 9 or row > 19 SHALL be clipped, never drawn and never wrapped.
REQ-020 Piece pixel colour: I 0x0FF, O 0xFF0, T 0xA0F, S 0x0F0, Z 0xF00, J 0x00F, L 0xF80; pixels with sub-pixel 0 or CELL-1 in either axis SHALL be 0x000 (mino outline).
REQ-021 rgb_out SHALL be 0x000 when delayed hblnk or vblnk is high; otherwise the piece colour on a hit, else delayed rgb_in.
REQ-022 block == 7 SHALL draw nothing (pure passthrough).
REQ-023 Overlapping minos (not possible from a valid table) SHALL still produce a single colour.

Reset
REQ-024 While rst_n is low, all outputs and pipeline registers SHALL be 0, and the shadow block SHALL be 7.
REQ-025 Counters SHALL be 0, and reset release mid-frame SHALL give passthrough until the first vblnk_in rising edge.

Configuration
REQ-026 With macro DRAW_TETROMINO_GRID_EN defined, non-piece board pixels with sub-pixel 0 in either axis SHALL be 0x333 (grid).
REQ-027 Without DRAW_TETROMINO_GRID_EN, those pixels SHALL pass rgb_in and no grid logic SHALL be built.

Verification
REQ-028 O, xpos=4, ypos=0, rot=0, latched at vblank; pixel (405,65) -> rgb_out 0xFF0 two cycles later; pixel (381,65) -> rgb_in.
REQ-029 I, xpos=8, ypos=5, rot=0 -> cells 8,9 drawn at row 6; cells 10,11 clipped; pixel (280+240+5, 60+6*24+5) -> rgb_in.
REQ-030 T, xpos=0, ypos=0, rot=1 -> offsets (1,0)(1,1)(2,1)(1,2); cell (2,1) pixel (333,89) -> 0xA0F; cell (1,0) sub-pixel 0 -> 0x000.
REQ-031 xpos changed from 4 to 5 mid-active-frame -> drawing unchanged until after the next vblnk_in rise, then shifted by CELL pixels.
REQ-032 rst_n pulsed low mid-line -> outputs 0 asynchronously; after release, block 7 passthrough until vblank; a grid-build run shows 0x333 at (280,60).

Source files
------------

// File: rtl/draw_tetromino.sv
// draw_tetromino: overlays the falling tetromino on a 10x20 board in a 2-cycle pixel pipeline.
// Define DRAW_TETROMINO_GRID_EN to paint a 0x333 cell grid under empty board pixels.
module draw_tetromino #(
    parameter int BOARD_X0 = 280,
    parameter int BOARD_Y0 = 60,
    parameter int CELL     = 24
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [2:0]  block,
    input  logic [2:0]  rot,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);
    localparam int SW = $clog2(CELL);

    logic [10:0]   h1, v1;
    logic          hs1, vs1, hb1, vb1;
    logic [11:0]   rgb1;
    logic [11:0]   xs, ys;
    logic [2:0]    blk;
    logic [1:0]    rt;
    logic [3:0]    col;
    logic [4:0]    row;
    logic [SW-1:0] sx, sy;
    logic          h_on, v_on;
    logic          hit, edge_px;
    logic [15:0]   offs;
    logic [12:0]   mx, my;
    logic [11:0]   bg, rgb_next;
    logic          unused_rot;

    assign unused_rot = rot[2];

    // Four minos as {dx,dy} nibbles, rotated clockwise r times inside the piece box.
    function automatic logic [15:0] shape(input logic [2:0] b, input logic [1:0] r);
        logic [15:0] s;
        logic [1:0]  dx, dy;
        case (b)
            3'd0:    s = 16'h159D;
            3'd1:    s = 16'h4859;
            3'd2:    s = 16'h4159;
            3'd3:    s = 16'h4815;
            3'd4:    s = 16'h0459;
            3'd5:    s = 16'h0159;
            3'd6:    s = 16'h8159;
            default: s = 16'h0000;
        endcase
        for (int k = 0; k < 3; k++)
            if (k < int'(r) && b != 3'd1)
                for (int i = 0; i < 4; i++) begin
                    dx = s[4*i+3 -: 2];
                    dy = s[4*i+1 -: 2];
                    s[4*i+3 -: 2] = (b == 3'd0 ? 2'd3 : 2'd2) - dy;
                    s[4*i+1 -: 2] = dx;
                end
        return s;
    endfunction

    function automatic logic [11:0] colour(input logic [2:0] b);
        case (b)
            3'd0:    return 12'h0FF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'hA0F;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF00;
            3'd5:    return 12'h00F;
            3'd6:    return 12'hF80;
            default: return 12'h000;
        endcase
    endfunction

    // Stage 1: delay the timing stream and snapshot the piece on the vblank rising edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {h1, v1, hs1, vs1, hb1, vb1, rgb1} <= '0;
            {xs, ys, rt} <= '0;
            blk <= 3'd7;
        end else begin
            {h1, v1, hs1, vs1, hb1, vb1, rgb1} <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
            if (vblnk_in && !vb1) begin
                xs  <= xpos;
                ys  <= ypos;
                blk <= block;
                rt  <= rot[1:0];
            end
        end
    end

    // Column/sub-pixel counters, restarted at the board's left edge; stay aligned with stage 1.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            sx   <= '0;
            h_on <= 1'b0;
        end else if (hcount_in == 11'(BOARD_X0)) begin
            col  <= '0;
            sx   <= '0;
            h_on <= 1'b1;
        end else if (sx == SW'(CELL - 1)) begin
            sx  <= '0;
            col <= col + 4'd1;
            if (col == 4'd9) h_on <= 1'b0;
        end else begin
            sx <= sx + 1'b1;
        end
    end

    // Row/sub-pixel counters, stepped once per line start and restarted at the board's top row.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            sy   <= '0;
            v_on <= 1'b0;
        end else if (hcount_in == 11'd0) begin
            if (vcount_in == 11'(BOARD_Y0)) begin
                row  <= '0;
                sy   <= '0;
                v_on <= 1'b1;
            end else if (sy == SW'(CELL - 1)) begin
                sy  <= '0;
                row <= row + 5'd1;
                if (row == 5'd19) v_on <= 1'b0;
            end else begin
                sy <= sy + 1'b1;
            end
        end
    end

    // Hit test against the four minos (13-bit sums, so off-board minos never match) and colour select.
    always_comb begin
        offs = shape(blk, rt);
        hit  = 1'b0;
        mx   = '0;
        my   = '0;
        for (int i = 0; i < 4; i++) begin
            mx  = {1'b0, xs} + 13'(offs[4*i+3 -: 2]);
            my  = {1'b0, ys} + 13'(offs[4*i+1 -: 2]);
            hit = hit | (mx == 13'(col) && my == 13'(row));
        end
        hit     = hit && h_on && v_on && blk != 3'd7;
        edge_px = sx == '0 || sy == '0 || sx == SW'(CELL - 1) || sy == SW'(CELL - 1);
`ifdef DRAW_TETROMINO_GRID_EN
        bg = (h_on && v_on && (sx == '0 || sy == '0)) ? 12'h333 : rgb1;
`else
        bg = rgb1;
`endif
        rgb_next = (hb1 || vb1) ? 12'h000 : hit ? (edge_px ? 12'h000 : colour(blk)) : bg;
    end

    // Stage 2: registered outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} <= '0;
        end else begin
            {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} <= {h1, v1, hs1, vs1, hb1, vb1, rgb_next};
        end
    end
endmodule
